// File: rtl/mp3_tag_ctrl_pkg.sv
// Shared types and default widths for the MP3 tag-store controller.
package mp3_tag_ctrl_pkg;

  localparam int DEF_TAG_WIDTH = 21;
  localparam int DEF_IDX_WIDTH = 5;
  localparam int STAT_W        = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mp3_tag_stats.sv
// Saturating hit/miss counters for the tag controller (built only with MP3_TAG_CTRL_STATS_EN).
module mp3_tag_stats
  import mp3_tag_ctrl_pkg::*;
#(
  parameter int CNT_W = STAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_hit,
  input  logic             inc_miss,
  output logic [CNT_W-1:0] stat_hits,
  output logic [CNT_W-1:0] stat_misses
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (inc_hit)  stat_hits   <= sat_inc(stat_hits);
      if (inc_miss) stat_misses <= sat_inc(stat_misses);
    end
  end

endmodule

// File: rtl/mp3_tag_ctrl.sv
// Tag-store controller: clears a single-port tag SRAM after reset, then serves
// one write or lookup per cycle with a 2-cycle lookup latency.
// Optional hit/miss statistics are enabled by defining MP3_TAG_CTRL_STATS_EN.
module mp3_tag_ctrl
  import mp3_tag_ctrl_pkg::*;
#(
  parameter int TAG_WIDTH = DEF_TAG_WIDTH,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [IDX_WIDTH-1:0] req_idx,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [TAG_WIDTH-1:0] resp_tag,
  output logic                 init_done,
  output logic                 sram_csb0,
  output logic                 sram_web0,
  output logic [IDX_WIDTH-1:0] sram_addr0,
  output logic [TAG_WIDTH:0]   sram_din0,
  input  logic [TAG_WIDTH:0]   sram_dout0
`ifdef MP3_TAG_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_hits,
  output logic [STAT_W-1:0]    stat_misses
`endif
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = {IDX_WIDTH{1'b1}};

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   sweep_q, sweep_d;
  logic                   lookup_acc;
  logic                   vld_p0;
  logic [TAG_WIDTH-1:0]   tag_p0;

  // An entry only hits when its valid bit is set; a cleared entry never matches, even tag 0.
  function automatic logic tag_hit(input logic [TAG_WIDTH:0]   word,
                                   input logic [TAG_WIDTH-1:0] tag);
    return word[TAG_WIDTH] && (word[TAG_WIDTH-1:0] == tag);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // While rst is high the SRAM port is parked so a held reset never writes.
  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    req_ready  = 1'b0;
    lookup_acc = 1'b0;
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    if (!rst) begin
      case (state_q)
        INIT: begin
          sram_csb0  = 1'b0;
          sram_web0  = 1'b0;
          sram_addr0 = sweep_q;
          sram_din0  = '0;
          sweep_d    = sweep_q + 1'b1;
          if (sweep_q == LAST_IDX) state_d = RUN;
        end
        RUN: begin
          req_ready = 1'b1;
          if (req_valid) begin
            sram_csb0  = 1'b0;
            sram_addr0 = req_idx;
            if (req_write) begin
              sram_web0 = 1'b0;
              sram_din0 = {1'b1, req_tag};
            end else begin
              lookup_acc = 1'b1;
            end
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  assign init_done = (state_q == RUN) && !rst;

  // Stage p0: lookup issued, SRAM read in flight, compare tag held alongside.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= lookup_acc;
  end

  always_ff @(posedge clk) begin
    if (lookup_acc) tag_p0 <= req_tag;
  end

  // Stage p1: SRAM word captured and compared; presented as the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_tag   <= '0;
    end else begin
      resp_valid <= vld_p0;
      if (vld_p0) begin
        resp_hit <= tag_hit(sram_dout0, tag_p0);
        resp_tag <= sram_dout0[TAG_WIDTH-1:0];
      end
    end
  end

`ifdef MP3_TAG_CTRL_STATS_EN
  mp3_tag_stats #(
    .CNT_W (STAT_W)
  ) u_stats (
    .clk         (clk),
    .rst         (rst),
    .clr         (state_q == INIT),
    .inc_hit     (resp_valid && resp_hit),
    .inc_miss    (resp_valid && !resp_hit),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );
`endif

endmodule

// File: tb/tb_mp3_tag_ctrl.sv
// Directed bench for mp3_tag_ctrl with a behavioural single-port tag SRAM.
module tb_mp3_tag_ctrl;

  localparam int TW = 21;
  localparam int IW = 5;
  localparam int DEPTH = 1 << IW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [IW-1:0] req_idx = '0;
  logic [TW-1:0] req_tag = '0;
  logic          resp_valid;
  logic          resp_hit;
  logic [TW-1:0] resp_tag;
  logic          init_done;
  logic          sram_csb0;
  logic          sram_web0;
  logic [IW-1:0] sram_addr0;
  logic [TW:0]   sram_din0;
  logic [TW:0]   sram_dout0;
`ifdef MP3_TAG_CTRL_STATS_EN
  logic [15:0]   stat_hits;
  logic [15:0]   stat_misses;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mp3_tag_ctrl #(.TAG_WIDTH(TW), .IDX_WIDTH(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_idx    (req_idx),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_tag   (resp_tag),
    .init_done  (init_done),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
`ifdef MP3_TAG_CTRL_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: address/data captured at posedge, read data valid the following cycle.
  logic [TW:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = {(TW+1){1'b1}};
    sram_dout0 = '0;
  end
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= mem[sram_addr0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called right after rst drops at a negedge; checks the whole clear sweep.
  task automatic run_init();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_idx   = 5'd31;
    req_tag   = 21'h1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("sweep_csb", sram_csb0, 0);
      chk("sweep_web", sram_web0, 0);
      chk("sweep_addr", sram_addr0, i);
      chk("sweep_din", sram_din0, 0);
      chk("sweep_ready", req_ready, 0);
      chk("sweep_done", init_done, 0);
      chk("sweep_rv", resp_valid, 0);
      if (i == DEPTH - 1) req_valid = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("run_ready", req_ready, 1);
    chk("run_done", init_done, 1);
    chk("run_idle_csb", sram_csb0, 1);
    chk("run_idle_web", sram_web0, 1);
  endtask

  task automatic issue(input logic v, input logic wr, input logic [IW-1:0] idx, input logic [TW-1:0] tag);
    req_valid = v;
    req_write = wr;
    req_idx   = idx;
    req_tag   = tag;
    @(negedge clk);
  endtask

  typedef struct {
    logic          vld;
    logic          wr;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          exp_hit;
    logic [TW-1:0] exp_tag;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  initial begin
    logic exp_rv;

    tbl[0]  = '{1, 1, 5'd5,  21'h1ABCD,  0, 21'h0};
    tbl[1]  = '{1, 0, 5'd5,  21'h1ABCD,  1, 21'h1ABCD};
    tbl[2]  = '{1, 0, 5'd7,  21'h0,      0, 21'h0};
    tbl[3]  = '{1, 0, 5'd5,  21'h00001,  0, 21'h1ABCD};
    tbl[4]  = '{1, 1, 5'd1,  21'h1FFFFF, 0, 21'h0};
    tbl[5]  = '{1, 1, 5'd2,  21'h0,      0, 21'h0};
    tbl[6]  = '{1, 1, 5'd3,  21'h12345,  0, 21'h0};
    tbl[7]  = '{1, 0, 5'd1,  21'h1FFFFF, 1, 21'h1FFFFF};
    tbl[8]  = '{1, 0, 5'd2,  21'h0,      1, 21'h0};
    tbl[9]  = '{1, 0, 5'd3,  21'h12345,  1, 21'h12345};
    tbl[10] = '{1, 0, 5'd5,  21'h1ABCD,  1, 21'h1ABCD};
    tbl[11] = '{1, 1, 5'd5,  21'h2,      0, 21'h0};
    tbl[12] = '{1, 0, 5'd5,  21'h2,      1, 21'h2};
    tbl[13] = '{1, 0, 5'd31, 21'h1,      0, 21'h0};
    tbl[14] = '{0, 0, 5'd0,  21'h0,      0, 21'h0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_hit", resp_hit, 0);
    chk("rst_tag", resp_tag, 0);
    chk("rst_done", init_done, 0);
    chk("rst_csb", sram_csb0, 1);
    chk("rst_web", sram_web0, 1);
    @(negedge clk);
    rst = 1'b0;
    run_init();

    // Table of writes/lookups, one per cycle; responses checked two cycles later
    @(negedge clk);
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) begin
        exp_rv = tbl[i-2].vld && !tbl[i-2].wr;
        chk($sformatf("v%0d_rv", i-2), resp_valid, exp_rv);
        if (exp_rv) begin
          chk($sformatf("v%0d_hit", i-2), resp_hit, tbl[i-2].exp_hit);
          chk($sformatf("v%0d_tag", i-2), resp_tag, tbl[i-2].exp_tag);
        end
      end
      if (i < NV) begin
        req_valid = tbl[i].vld;
        req_write = tbl[i].wr;
        req_idx   = tbl[i].idx;
        req_tag   = tbl[i].tag;
        #1;
        chk($sformatf("v%0d_csb", i), sram_csb0, !tbl[i].vld);
        chk($sformatf("v%0d_web", i), sram_web0, !(tbl[i].vld && tbl[i].wr));
        if (tbl[i].vld) chk($sformatf("v%0d_addr", i), sram_addr0, tbl[i].idx);
        if (tbl[i].vld && tbl[i].wr) chk($sformatf("v%0d_din", i), sram_din0, {1'b1, tbl[i].tag});
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Reset at sweep index 10 restarts the sweep
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("mid_addr10", sram_addr0, 10);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_csb", sram_csb0, 1);
    chk("mid_rst_ready", req_ready, 0);
    rst = 1'b0;
    run_init();

    // Reset while a lookup is in flight drops its response
    @(negedge clk);
    issue(1, 0, 5'd5, 21'h0);
    req_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("drop_rv", resp_valid, 0);
    end
    rst = 1'b0;
    run_init();

`ifdef MP3_TAG_CTRL_STATS_EN
    chk("stat_hits_clr", stat_hits, 0);
    chk("stat_misses_clr", stat_misses, 0);
    @(negedge clk);
    issue(1, 1, 5'd4, 21'h7);
    issue(1, 0, 5'd4, 21'h7);
    issue(1, 0, 5'd4, 21'h7);
    issue(1, 0, 5'd4, 21'h8);
    issue(1, 0, 5'd9, 21'h0);
    issue(1, 0, 5'd4, 21'h7);
    repeat (4) issue(0, 0, 5'd0, 21'h0);
    chk("stat_hits3", stat_hits, 3);
    chk("stat_misses2", stat_misses, 2);
    for (int i = 0; i < 65536; i++) issue(1, 0, 5'd4, 21'h7);
    repeat (4) issue(0, 0, 5'd0, 21'h0);
    chk("stat_hits_sat", stat_hits, 16'hFFFF);
    chk("stat_misses_hold", stat_misses, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
